// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID register and the imem request.
// Ports: clk/rst (sync, active-high); stall/flush/PCSrc + redirect targets from
//   ID/hazard logic; imemAddr/imemReq/imemInst/imemReady to instruction memory;
//   ifidInst/ifidPC4/ifidValid to decode; pc and fetchCount for observation.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branchTarget,
    input  logic [25:0] jumpIndex,
    input  logic [31:0] jrTarget,
    input  logic [31:0] idPC4,
    output logic [31:0] imemAddr,
    output logic        imemReq,
    input  logic [31:0] imemInst,
    input  logic        imemReady,
    output logic [31:0] ifidInst,
    output logic [31:0] ifidPC4,
    output logic        ifidValid,
    output logic [31:0] pc,
    output logic [31:0] fetchCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        redirectPending, pending_n;
    logic [31:0] redirectPC, rpc_n;
    logic [31:0] pc_n, inst_n, pc4_n, cnt_n;
    logic        valid_n;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = (PCSrc != 2'b00);
    assign imemAddr = pc;
    assign imemReq  = (state != BOOT);

    always_comb begin
        target = pc_plus4;
        unique case (PCSrc)
            2'b01:   target = branchTarget;
            2'b10:   target = {idPC4[31:28], jumpIndex, 2'b00};
            2'b11:   target = jrTarget;
            default: target = pc_plus4;
        endcase
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        inst_n    = ifidInst;
        pc4_n     = ifidPC4;
        valid_n   = ifidValid;
        cnt_n     = fetchCount;
        pending_n = redirectPending;
        rpc_n     = redirectPC;

        unique case (state)
            BOOT: begin
                inst_n  = NOP_INST;
                valid_n = 1'b0;
                state_n = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        pc_n    = target;
                        inst_n  = NOP_INST;
                        valid_n = 1'b0;
                    end else if (imemReady) begin
                        pc_n  = pc_plus4;
                        pc4_n = pc_plus4;
                        if (flush) begin
                            inst_n  = NOP_INST;
                            valid_n = 1'b0;
                        end else begin
                            inst_n  = imemInst;
                            valid_n = 1'b1;
                            cnt_n   = fetchCount + 32'd1;
                        end
                    end else begin
                        inst_n  = NOP_INST;
                        valid_n = 1'b0;
                        state_n = MISS;
                    end
                end
            end
            MISS: begin
                if (!stall) begin
                    if (imemReady) begin
                        state_n = RUN;
                        if (redirectPending || redirect) begin
                            // The live redirect is newer than any pending one.
                            pc_n      = redirect ? target : redirectPC;
                            pending_n = 1'b0;
                            inst_n    = NOP_INST;
                            valid_n   = 1'b0;
                        end else begin
                            pc_n  = pc_plus4;
                            pc4_n = pc_plus4;
                            if (flush) begin
                                inst_n  = NOP_INST;
                                valid_n = 1'b0;
                            end else begin
                                inst_n  = imemInst;
                                valid_n = 1'b1;
                                cnt_n   = fetchCount + 32'd1;
                            end
                        end
                    end else begin
                        // Address must stay put; remember the redirect instead.
                        inst_n  = NOP_INST;
                        valid_n = 1'b0;
                        if (redirect) begin
                            pending_n = 1'b1;
                            rpc_n     = target;
                        end
                    end
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= BOOT;
            pc              <= RESET_PC;
            ifidInst        <= NOP_INST;
            ifidPC4         <= 32'd0;
            ifidValid       <= 1'b0;
            fetchCount      <= 32'd0;
            redirectPending <= 1'b0;
            redirectPC      <= 32'd0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            ifidInst        <= inst_n;
            ifidPC4         <= pc4_n;
            ifidValid       <= valid_n;
            fetchCount      <= cnt_n;
            redirectPending <= pending_n;
            redirectPC      <= rpc_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a queue of expected IF/ID deliveries.
// Instruction memory returns a tag derived from the requested address.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  PCSrc;
    logic [31:0] branchTarget;
    logic [25:0] jumpIndex;
    logic [31:0] jrTarget;
    logic [31:0] idPC4;
    logic [31:0] imemAddr;
    logic        imemReq;
    logic [31:0] imemInst;
    logic        imemReady;
    logic [31:0] ifidInst;
    logic [31:0] ifidPC4;
    logic        ifidValid;
    logic [31:0] pc;
    logic [31:0] fetchCount;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] epc;
    logic [31:0] ecnt;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign imemInst = tag(imemAddr);

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .PCSrc(PCSrc),
        .branchTarget(branchTarget), .jumpIndex(jumpIndex),
        .jrTarget(jrTarget), .idPC4(idPC4), .imemAddr(imemAddr),
        .imemReq(imemReq), .imemInst(imemInst), .imemReady(imemReady),
        .ifidInst(ifidInst), .ifidPC4(ifidPC4), .ifidValid(ifidValid),
        .pc(pc), .fetchCount(fetchCount)
    );

    task automatic chk(input string tg, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One clock, then compare IF/ID against the scoreboard head.
    task automatic step_sb();
        bit   expv;
        exp_t e;
        cyc();
        expv = (q.size() != 0);
        chk("ifidValid", {31'd0, ifidValid}, {31'd0, expv});
        if (expv) begin
            e = q.pop_front();
            if (ifidValid === 1'b1) begin
                chk("ifidInst", ifidInst, e.inst);
                chk("ifidPC4", ifidPC4, e.pc4);
            end
        end
    endtask

    task automatic normal(input int n);
        for (int i = 0; i < n; i++) begin
            chk("imemAddr", imemAddr, epc);
            q.push_back('{tag(epc), epc + 32'd4});
            epc  = epc + 32'd4;
            ecnt = ecnt + 32'd1;
            step_sb();
            chk("pc", pc, epc);
            chk("fetchCount", fetchCount, ecnt);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; PCSrc = 2'b00;
        branchTarget = '0; jumpIndex = '0; jrTarget = '0; idPC4 = '0;
        imemReady = 1'b1;
        cyc();
        cyc();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, ifidValid}, 32'd0);
        chk("rst_inst", ifidInst, 32'h0);
        chk("rst_pc4", ifidPC4, 32'h0);
        chk("rst_cnt", fetchCount, 32'h0);
        chk("rst_req", {31'd0, imemReq}, 32'd0);

        rst = 1'b0;
        chk("boot_req", {31'd0, imemReq}, 32'd0);
        step_sb();
        chk("boot_pc", pc, 32'h0);
        chk("run_req", {31'd0, imemReq}, 32'd1);
        epc = 32'h0; ecnt = 32'h0;
        normal(4);

        // branch with flush at pc=0x10
        PCSrc = 2'b01; flush = 1'b1; branchTarget = 32'h40;
        step_sb();
        chk("br_pc", pc, 32'h40);
        chk("br_cnt", fetchCount, ecnt);
        PCSrc = 2'b00; flush = 1'b0;
        epc = 32'h40;
        normal(1);

        // jump and jump-register
        PCSrc = 2'b10; idPC4 = 32'hA000_0008; jumpIndex = 26'h0000010;
        step_sb();
        chk("j_pc", pc, 32'hA000_0040);
        PCSrc = 2'b11; jrTarget = 32'h1234_5678;
        step_sb();
        chk("jr_pc", pc, 32'h1234_5678);
        PCSrc = 2'b00;
        epc = 32'h1234_5678;
        normal(1);

        // PC wrap at the top of the address space
        PCSrc = 2'b11; jrTarget = 32'hFFFF_FFFC;
        step_sb();
        PCSrc = 2'b00;
        epc = 32'hFFFF_FFFC;
        normal(2);

        // flush alone squashes the load but fetch still advances
        flush = 1'b1;
        step_sb();
        flush = 1'b0;
        epc = epc + 32'd4;
        chk("fl_pc", pc, epc);
        chk("fl_inst", ifidInst, 32'h0);
        chk("fl_cnt", fetchCount, ecnt);
        normal(1);

        // stall with a redirect asserted: everything frozen
        stall = 1'b1; PCSrc = 2'b01; branchTarget = 32'h200;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("st_pc", pc, epc);
            chk("st_cnt", fetchCount, ecnt);
            chk("st_inst", ifidInst, tag(epc - 32'd4));
            chk("st_pc4", ifidPC4, epc);
            chk("st_valid", {31'd0, ifidValid}, 32'd1);
        end
        stall = 1'b0; PCSrc = 2'b00;
        normal(2);
        normal(3);
        chk("pre_miss_pc", pc, 32'h20);

        // miss with redirect arriving mid-miss
        imemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                PCSrc = 2'b01; branchTarget = 32'h80;
            end else begin
                PCSrc = 2'b00;
            end
            chk("miss_addr", imemAddr, 32'h20);
            step_sb();
            chk("miss_addr_q", imemAddr, 32'h20);
            chk("miss_req", {31'd0, imemReq}, 32'd1);
        end
        PCSrc = 2'b00; imemReady = 1'b1;
        step_sb();
        chk("miss_rd_pc", pc, 32'h80);
        chk("miss_rd_cnt", fetchCount, ecnt);
        epc = 32'h80;
        normal(1);

        // plain miss then delivery out of MISS
        imemReady = 1'b0;
        step_sb();
        chk("miss2_pc", pc, epc);
        imemReady = 1'b1;
        normal(1);

        // reset while a redirect is pending in MISS
        imemReady = 1'b0;
        step_sb();
        PCSrc = 2'b01; branchTarget = 32'h300;
        step_sb();
        PCSrc = 2'b00;
        rst = 1'b1;
        step_sb();
        chk("rm_pc", pc, 32'h0);
        chk("rm_req", {31'd0, imemReq}, 32'd0);
        chk("rm_cnt", fetchCount, 32'h0);
        rst = 1'b0; imemReady = 1'b1;
        step_sb();
        chk("rm_boot_pc", pc, 32'h0);
        epc = 32'h0; ecnt = 32'h0;
        normal(1);

        chk("sb_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
